// File: rtl/sequence_generator.sv
// ---------------------------------------------------------------------------
// sequence_generator
//
// Tick-paced serial bit-pattern transmitter, the counterpart of the sequence
// detector. A start request in IDLE captures an N-bit pattern, which is then
// shifted out MSB-first, one bit per tick. The pattern is repeated
// max(reps,1) times with no gap between repetitions. A one-clk done pulse
// follows the last bit.
//
// Optional feature macro: SEQ_GEN_CONTINUOUS_EN
//   When defined, the `continuous` port is added. If continuous is high at
//   the end-of-pattern tick of the last repetition, the pattern is reloaded
//   and transmission keeps going.
//
// Parameters
//   N           pattern length in bits (>= 2)
//   IDLE_LEVEL  value driven on `out` when not transmitting
//
// Ports
//   clk            clock
//   reset          synchronous, active-high reset
//   tick           one-clk-wide bit-rate enable
//   start          transmission request, sampled every clk while in IDLE
//   pattern[N-1:0] bits to send, MSB first, captured on an accepted start
//   reps[3:0]      transmission count, 0 is treated as 1
//   continuous     (SEQ_GEN_CONTINUOUS_EN only) loop forever while high
//   out            serial bit stream
//   busy           high while shifting
//   done           one-clk pulse after the final bit
//   current_state  FSM state: IDLE=00, SHIFT=01, DONE=10
// ---------------------------------------------------------------------------
module sequence_generator #(
  parameter int   N          = 8,
  parameter logic IDLE_LEVEL = 1'b0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         tick,
  input  logic         start,
  input  logic [N-1:0] pattern,
  input  logic [3:0]   reps,
`ifdef SEQ_GEN_CONTINUOUS_EN
  input  logic         continuous,
`endif
  output logic         out,
  output logic         busy,
  output logic         done,
  output logic [1:0]   current_state
);

  localparam int            CW       = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(N - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    DONE  = 2'b10
  } state_t;

  state_t         state_q, state_d;
  logic [N-1:0]   shreg_q, shreg_d;
  logic [N-1:0]   pat_q, pat_d;
  logic [CW-1:0]  bit_cnt_q, bit_cnt_d;
  logic [3:0]     rep_cnt_q, rep_cnt_d;
  logic           cont_en;

`ifdef SEQ_GEN_CONTINUOUS_EN
  assign cont_en = continuous;
`else
  assign cont_en = 1'b0;
`endif

  // State register. Reset aborts any transmission immediately and clears all
  // captured data, so no done pulse can follow a reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      shreg_q   <= '0;
      pat_q     <= '0;
      bit_cnt_q <= '0;
      rep_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      shreg_q   <= shreg_d;
      pat_q     <= pat_d;
      bit_cnt_q <= bit_cnt_d;
      rep_cnt_q <= rep_cnt_d;
    end
  end

  // Next-state logic. Everything holds unless a start is accepted in IDLE or
  // a tick arrives in SHIFT. The end-of-pattern tick either reloads the
  // pattern (more repetitions, or continuous mode) or moves on to DONE.
  // The unused encoding 11 falls into the default branch and recovers to IDLE.
  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    pat_d     = pat_q;
    bit_cnt_d = bit_cnt_q;
    rep_cnt_d = rep_cnt_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          pat_d     = pattern;
          shreg_d   = pattern;
          bit_cnt_d = '0;
          rep_cnt_d = (reps == 4'd0) ? 4'd0 : reps - 4'd1;
          state_d   = SHIFT;
        end
      end
      SHIFT: begin
        if (tick) begin
          if (bit_cnt_q != LAST_BIT) begin
            shreg_d   = shreg_q << 1;
            bit_cnt_d = bit_cnt_q + CW'(1);
          end else if (rep_cnt_q != 4'd0) begin
            shreg_d   = pat_q;
            bit_cnt_d = '0;
            rep_cnt_d = rep_cnt_q - 4'd1;
          end else if (cont_en) begin
            shreg_d   = pat_q;
            bit_cnt_d = '0;
          end else begin
            state_d   = DONE;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Outputs are decoded purely from registered state.
  assign out           = (state_q == SHIFT) ? shreg_q[N-1] : IDLE_LEVEL;
  assign busy          = (state_q == SHIFT);
  assign done          = (state_q == DONE);
  assign current_state = state_q;

endmodule

// File: tb/tb_sequence_generator.sv
// ---------------------------------------------------------------------------
// tb_sequence_generator
//
// Self-checking bench for sequence_generator with N=4. A queue-based
// reference model (bits waiting to be sent) is compared against the DUT on
// every falling edge. On top of that, a table of transmissions is run and
// measured (busy length, tick-sampled bit stream, done pulses, overlapping
// 1011 detections), followed by hand-written reset, ignored-start and
// held-start sequences, and a randomized phase.
// ---------------------------------------------------------------------------
module tb_sequence_generator;

  localparam int   N          = 4;
  localparam logic IDLE_LEVEL = 1'b0;

  logic         clk = 1'b0;
  logic         reset;
  logic         tick;
  logic         start;
  logic [N-1:0] pattern;
  logic [3:0]   reps;
  logic         continuous;
  logic         out;
  logic         busy;
  logic         done;
  logic [1:0]   current_state;

  int checks   = 0;
  int failures = 0;
  bit chk_en   = 1'b0;

  always #5 clk = ~clk;

  sequence_generator #(
    .N          (N),
    .IDLE_LEVEL (IDLE_LEVEL)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .tick          (tick),
    .start         (start),
    .pattern       (pattern),
    .reps          (reps),
`ifdef SEQ_GEN_CONTINUOUS_EN
    .continuous    (continuous),
`endif
    .out           (out),
    .busy          (busy),
    .done          (done),
    .current_state (current_state)
  );

  // Reference model: a queue of bits still to be transmitted, plus a phase
  // (0 idle, 1 sending, 2 done pulse). The head of the queue is the bit on
  // the line; each tick while sending consumes one bit.
  bit           model_q[$];
  logic [N-1:0] model_pat;
  int           model_mode = 0;

  task automatic loadBits(input logic [N-1:0] p, input int times);
    for (int t = 0; t < times; t++)
      for (int i = N - 1; i >= 0; i--)
        model_q.push_back(p[i]);
  endtask

  task automatic modelStep();
    logic cont_in;
`ifdef SEQ_GEN_CONTINUOUS_EN
    cont_in = continuous;
`else
    cont_in = 1'b0;
`endif
    if (reset) begin
      model_q.delete();
      model_mode = 0;
    end else if (model_mode == 0) begin
      if (start) begin
        model_q.delete();
        model_pat = pattern;
        loadBits(pattern, (reps == 4'd0) ? 1 : int'(reps));
        model_mode = 1;
      end
    end else if (model_mode == 1) begin
      if (tick) begin
        void'(model_q.pop_front());
        if (model_q.size() == 0) begin
          if (cont_in) loadBits(model_pat, 1);
          else model_mode = 2;
        end
      end
    end else begin
      model_mode = 0;
    end
  endtask

  initial forever begin
    @(posedge clk);
    modelStep();
  end

  // Compare all DUT outputs against the model.
  task automatic checkOutput(input string name);
    logic       exp_out;
    logic       exp_busy;
    logic       exp_done;
    logic [1:0] exp_state;
    exp_out   = (model_mode == 1 && model_q.size() > 0) ? model_q[0] : IDLE_LEVEL;
    exp_busy  = (model_mode == 1);
    exp_done  = (model_mode == 2);
    exp_state = (model_mode == 1) ? 2'b01 : (model_mode == 2) ? 2'b10 : 2'b00;
    checks++;
    if (out !== exp_out || busy !== exp_busy || done !== exp_done || current_state !== exp_state) begin
      failures++;
      $display("[TB] FAIL %s t=%0t got out=%b busy=%b done=%b state=%b expected out=%b busy=%b done=%b state=%b",
               name, $time, out, busy, done, current_state, exp_out, exp_busy, exp_done, exp_state);
    end
  endtask

  always @(negedge clk) if (chk_en) checkOutput("model");

  task automatic checkVal(input string name, input longint actual, input longint expected);
    checks++;
    if (actual != expected) begin
      failures++;
      $display("[TB] FAIL %s got=%0h expected=%0h", name, actual, expected);
    end
  endtask

  task automatic stepClk();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [N-1:0] pattern;
    logic [3:0]   reps;
    int           period;
    bit           glitch;
    int           exp_busy;
    logic [63:0]  exp_stream;
    int           exp_nbits;
    int           exp_dets;
  } vec_t;

  vec_t vecs[7];

  // Runs one transmission: start pulse (with a simultaneous tick that must be
  // ignored), then ticks every `period` clks. Records busy length, the bits a
  // tick-gated receiver would see, done pulses and overlapping 1011 hits.
  task automatic applyStimulus(input vec_t v, output int busy_cyc, output logic [63:0] stream,
                               output int nbits, output int dones, output int dets, output bit timeout);
    logic [3:0] hist;
    busy_cyc = 0; stream = '0; nbits = 0; dones = 0; dets = 0; timeout = 1'b1; hist = '0;
    start = 1'b1; pattern = v.pattern; reps = v.reps; tick = 1'b1;
    stepClk();
    start = 1'b0; tick = 1'b0;
    for (int cyc = 1; cyc <= 400; cyc++) begin
      if (busy) busy_cyc++;
      if (done) begin
        dones++;
        tick = 1'b0; start = 1'b0;
        stepClk();
        if (done) dones++;
        timeout = 1'b0;
        break;
      end
      start = 1'b0;
      if (v.glitch && cyc == 6) begin
        start = 1'b1; pattern = '0; reps = 4'd9;
      end
      tick = ((cyc % v.period) == 0);
      if (tick && busy) begin
        stream = {stream[62:0], out};
        nbits++;
        hist = {hist[2:0], out};
        if (nbits >= 4 && hist == 4'b1011) dets++;
      end
      stepClk();
    end
    tick = 1'b0; start = 1'b0;
  endtask

  task automatic runVector(input int idx, input string name);
    int          busy_cyc, nbits, dones, dets;
    logic [63:0] stream;
    bit          timeout;
    applyStimulus(vecs[idx], busy_cyc, stream, nbits, dones, dets, timeout);
    checkVal({name, "_timeout"}, timeout, 0);
    checkVal({name, "_busy"}, busy_cyc, vecs[idx].exp_busy);
    checkVal({name, "_stream"}, stream, vecs[idx].exp_stream);
    checkVal({name, "_nbits"}, nbits, vecs[idx].exp_nbits);
    checkVal({name, "_done"}, dones, 1);
    checkVal({name, "_detect"}, dets, vecs[idx].exp_dets);
  endtask

  initial begin
    int cnt;
    vecs[0] = '{4'b1011, 4'd0,  4, 1'b0, 16,  64'hB,                1,  1};
    vecs[1] = '{4'b1011, 4'd3,  4, 1'b0, 48,  64'hBBB,              12, 3};
    vecs[2] = '{4'b1011, 4'd1,  4, 1'b1, 16,  64'hB,                4,  1};
    vecs[3] = '{4'b0110, 4'd2,  1, 1'b0, 8,   64'h66,               8,  0};
    vecs[4] = '{4'b1000, 4'd15, 2, 1'b0, 120, 64'h0888888888888888, 60, 0};
    vecs[5] = '{4'b0001, 4'd1,  3, 1'b0, 12,  64'h1,                4,  0};
    vecs[6] = '{4'b1111, 4'd0,  1, 1'b0, 4,   64'hF,                4,  0};
    vecs[0].exp_nbits = 4;

    reset = 1'b1; tick = 1'b0; start = 1'b0; pattern = '0; reps = '0; continuous = 1'b0;
    stepClk();
    stepClk();
    chk_en = 1'b1;
    checkVal("reset_state", current_state, 0);
    checkVal("reset_out", out, IDLE_LEVEL);
    checkVal("reset_busy", busy, 0);
    checkVal("reset_done", done, 0);
    reset = 1'b0;
    stepClk();

    $display("[TB] table-driven transmissions");
    foreach (vecs[i]) runVector(i, $sformatf("vec%0d", i));

    $display("[TB] reset mid-transmission");
    start = 1'b1; pattern = 4'b1011; reps = 4'd0; tick = 1'b0;
    stepClk();
    start = 1'b0;
    for (int cyc = 1; cyc <= 8; cyc++) begin
      tick = ((cyc % 4) == 0);
      stepClk();
    end
    tick = 1'b0; reset = 1'b1;
    stepClk();
    checkVal("abort_state", current_state, 0);
    checkVal("abort_out", out, IDLE_LEVEL);
    checkVal("abort_busy", busy, 0);
    checkVal("abort_done", done, 0);
    reset = 1'b0;
    cnt = 0;
    for (int cyc = 0; cyc < 10; cyc++) begin
      tick = (cyc % 2 == 0);
      stepClk();
      if (done) cnt++;
    end
    tick = 1'b0;
    checkVal("abort_no_done", cnt, 0);
    runVector(0, "after_abort");

    $display("[TB] start held high with continuous tick");
    start = 1'b1; pattern = 4'b1011; reps = 4'd0; tick = 1'b1;
    stepClk();
    for (int k = 0; k < 18; k++) begin
      checkVal($sformatf("held_state%0d", k), current_state,
               ((k % 6) < 4) ? 2 'b01 : ((k % 6) == 4) ? 2'b10 : 2'b00);
      if ((k % 6) >= 4) checkVal($sformatf("held_out%0d", k), out, IDLE_LEVEL);
      stepClk();
    end
    start = 1'b0;
    for (int k = 0; k < 6; k++) stepClk();
    tick = 1'b0;
    stepClk();

`ifdef SEQ_GEN_CONTINUOUS_EN
    $display("[TB] continuous mode for ten patterns");
    continuous = 1'b1; start = 1'b1; pattern = 4'b1011; reps = 4'd0; tick = 1'b1;
    stepClk();
    start = 1'b0;
    cnt = 0;
    begin
      int busy_cyc;
      busy_cyc = 0;
      for (int k = 1; k <= 60; k++) begin
        if (busy) busy_cyc++;
        if (done) cnt++;
        if (k == 38) continuous = 1'b0;
        stepClk();
      end
      checkVal("cont_busy", busy_cyc, 40);
      checkVal("cont_done", cnt, 1);
    end
    tick = 1'b0;
    stepClk();
`endif

    $display("[TB] randomized phase");
    for (int i = 0; i < 3000; i++) begin
      reset   = ($urandom_range(0, 299) == 0);
      start   = ($urandom_range(0, 7) == 0);
      pattern = N'($urandom);
      reps    = ($urandom_range(0, 9) == 0) ? 4'($urandom) : 4'($urandom_range(0, 2));
      tick    = ($urandom_range(0, 2) == 0);
`ifdef SEQ_GEN_CONTINUOUS_EN
      continuous = ($urandom_range(0, 1) == 0);
`endif
      stepClk();
    end
    reset = 1'b0; start = 1'b0; tick = 1'b0;
    stepClk();
    chk_en = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
